// File: rtl/data_memory.sv
// Line-wide data memory with a fixed-latency request/ack handshake.
// Each transaction is acknowledged MEM_PENDING cycles after it is accepted; writes commit on the ack edge.
module data_memory #(
  parameter int MEM_PENDING = 10,
  parameter int DEPTH       = 512
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  input  logic         enable_i,
  input  logic         write_i,
  output logic         ack_o,
  output logic [255:0] data_o
);

  localparam int CNT_W = (MEM_PENDING > 2) ? $clog2(MEM_PENDING) : 1;
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_PENDING - 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [255:0]     memory [0:DEPTH-1];
  logic [IDX_W-1:0] line_idx;
  logic             unused_addr;

  // Byte offset within the line and everything above the array span are don't-care.
  assign line_idx    = addr_i[5 +: IDX_W];
  assign unused_addr = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ack_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = WAIT;
          count_d = '0;
        end
      end
      WAIT: begin
        // enable_i is ignored here: once accepted, a transaction always runs to its ack.
        if (count_q == CNT_LAST) begin
          ack_o   = 1'b1;
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
    endcase
  end

  // Storage carries no reset so contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (ack_o && write_i) begin
      memory[line_idx] <= data_i;
    end
  end

  assign data_o = memory[line_idx];

endmodule

// File: tb/tb_data_memory.sv
// Scoreboarded bench for data_memory: expected acks are queued when requests are driven and matched on ack.
module tb_data_memory;

  localparam int MP = 10;

  logic         clk_i, rst_i, enable_i, write_i, ack_o;
  logic [31:0]  addr_i;
  logic [255:0] data_i, data_o;

  data_memory #(.MEM_PENDING(MP), .DEPTH(512)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .addr_i  (addr_i),
    .data_i  (data_i),
    .enable_i(enable_i),
    .write_i (write_i),
    .ack_o   (ack_o),
    .data_o  (data_o)
  );

  typedef struct {
    int unsigned  cyc;
    logic         we;
    logic [255:0] data;
  } exp_t;

  exp_t         sb[$];
  logic [255:0] model [int];
  int           n_chk = 0;
  int           n_fail = 0;
  int           n_ack = 0;
  int           n_exp_ack = 0;
  int unsigned  cyc = 0;
  logic         ack_prev = 1'b0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ack monitor: every ack must match the oldest queued expectation.
  always @(negedge clk_i) begin : mon
    exp_t e;
    if (ack_o) begin
      n_ack++;
      chk("ack_width", 256'(ack_prev), 256'(0));
      if (sb.size() == 0) begin
        chk("spurious_ack", 256'(ack_o), 256'(0));
      end else begin
        e = sb.pop_front();
        chk("ack_cycle", 256'(cyc), 256'(e.cyc));
        if (!e.we) chk("rd_data", data_o, e.data);
      end
    end
    ack_prev <= ack_o;
  end

  task automatic expect_ack(input int unsigned c, input logic we, input logic [255:0] d);
    sb.push_back('{cyc: c, we: we, data: d});
    n_exp_ack++;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      @(negedge clk_i);
      #1;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 256'(sb.size()), 256'(0));
      sb.delete();
    end
  endtask

  // Single-cycle enable pulse; addr/data/write held until the next transaction.
  task automatic txn(input logic [31:0] addr, input logic [255:0] d, input logic we);
    int           idx = int'(addr[13:5]);
    logic         known = model.exists(idx);
    logic [255:0] old = known ? model[idx] : '0;
    int unsigned  ec;
    @(negedge clk_i);
    addr_i = addr; data_i = d; write_i = we; enable_i = 1'b1;
    ec = cyc + MP;
    expect_ack(ec, we, we ? d : old);
    @(negedge clk_i);
    enable_i = 1'b0;
    if (we) begin
      for (int i = 0; i < 40 && cyc != ec; i++) @(negedge clk_i);
      if (known) chk("wr_hold", dut.memory[idx], old);
      @(negedge clk_i);
      chk("wr_done", dut.memory[idx], d);
      model[idx] = d;
    end
    drain();
    if (!we) chk("rd_nomod", dut.memory[idx], old);
  endtask

  // Start a write, then assert reset during cycle k of it.
  task automatic rst_abort(input int k, input logic [31:0] addr, input logic [255:0] d);
    int          idx = int'(addr[13:5]);
    int unsigned tgt;
    @(negedge clk_i);
    addr_i = addr; data_i = d; write_i = 1'b1; enable_i = 1'b1;
    tgt = cyc + k;
    @(posedge clk_i);
    #2;
    enable_i = 1'b0;
    for (int i = 0; i < 40 && cyc != tgt; i++) begin
      @(posedge clk_i);
      #2;
    end
    rst_i = 1'b1;
    #1;
    chk("rst_ack_imm", 256'(ack_o), 256'(0));
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (MP + 5) @(negedge clk_i);
    chk("rst_no_write", dut.memory[idx], model[idx]);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned ec;
    rst_i = 1'b1; enable_i = 1'b1; write_i = 1'b0; addr_i = '0; data_i = '0;
    #1;
    chk("rst_ack", 256'(ack_o), 256'(0));
    repeat (3) @(negedge clk_i);
    chk("rst_ack_en", 256'(ack_o), 256'(0));
    enable_i = 1'b0;
    rst_i = 1'b0;

    // Known contents for every line used below.
    txn(32'h0000_0000, 256'h5, 1'b1);
    txn(32'h0000_0020, 256'h1111, 1'b1);
    txn(32'h0000_0060, 256'h333, 1'b1);
    txn(32'h0000_0400, 256'h4444, 1'b1);
    txn(32'h0000_00A0, 256'h55, 1'b1);
    txn(32'h0000_00C0, 256'h66, 1'b1);

    txn(32'h0000_0000, '0, 1'b0);
    txn(32'h0000_0020, 256'hDEADBEEF, 1'b1);
    txn(32'h0000_0020, '0, 1'b0);
    txn(32'h4000_0400, 256'hCAFE_F00D, 1'b1);
    chk("alias_line32", dut.memory[32], 256'hCAFE_F00D);
    chk("alias_line0", dut.memory[0], model[0]);
    txn(32'hFFFF_C020, '0, 1'b0);
    repeat (15) @(negedge clk_i);

    // Enable held high: back-to-back transactions spaced MP+1 cycles apart.
    @(negedge clk_i);
    addr_i = 32'h0000_0060; write_i = 1'b0; enable_i = 1'b1;
    ec = cyc + MP;
    expect_ack(ec, 1'b0, model[3]);
    expect_ack(ec + MP + 1, 1'b0, model[3]);
    expect_ack(ec + 2 * (MP + 1), 1'b0, model[3]);
    drain();
    enable_i = 1'b0;
    repeat (15) @(negedge clk_i);
    chk("held_nomod", dut.memory[3], model[3]);

    rst_abort(5, 32'h0000_00A0, 256'hBAD5);
    rst_abort(MP, 32'h0000_00C0, 256'hBAD6);

    txn(32'h0000_00A0, '0, 1'b0);
    repeat (5) @(negedge clk_i);
    chk("ack_count", 256'(n_ack), 256'(n_exp_ack));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 The block SHALL have parameter MEM_PENDING, default 10, meaning the number of cycles from transaction start to acknowledge, inclusive of the ack cycle.
REQ-002 The block SHALL have parameter DEPTH, default 512, meaning the number of 256-bit lines (16 KB).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port addr_i, input, 32 bits: byte address; line index = addr_i[13:5], and all other bits are ignored.
REQ-006 The block SHALL have port data_i, input, 256 bits: write line data.
REQ-007 The block SHALL have port enable_i, input, 1 bit: transaction request.
REQ-008 The block SHALL have port write_i, input, 1 bit: 1 = write, 0 = read; sampled in the ack cycle.
REQ-009 The block SHALL have port ack_o, output, 1 bit: one-cycle transaction-complete strobe.
REQ-010 The block SHALL have port data_o, output, 256 bits: read line data.
REQ-011 The block SHALL hold storage in an array named memory, indexed 0..DEPTH-1, 256 bits per entry, hierarchically accessible so benches can preload and inspect it directly.

Function
REQ-012 The controller SHALL be an FSM with two states: IDLE and WAIT, plus a count register of 4 bits (wide enough for MEM_PENDING-1).
REQ-013 In IDLE with enable_i=1 at a rising edge, the FSM SHALL go to WAIT with count=0; with enable_i=0 it SHALL stay in IDLE.
REQ-014 In WAIT, count SHALL increment by 1 each rising edge while count < MEM_PENDING-1.
REQ-015 When in WAIT with count == MEM_PENDING-1, ack_o SHALL be 1 (combinational decode of the registered state); otherwise ack_o SHALL be 0.
REQ-016 At the rising edge that ends the ack cycle, the FSM SHALL return to IDLE and clear count to 0.
REQ-017 With default parameters, ack_o SHALL be high during the 10th cycle after the edge that sampled enable_i=1.
REQ-018 At the edge ending the ack cycle, if write_i=1, memory[addr_i[13:5]] SHALL be written with data_i; read transactions SHALL leave memory unchanged.
REQ-019 data_o SHALL be combinational memory[addr_i[13:5]] at all times; it is valid for the requester during the ack cycle.
REQ-020 The requester SHALL hold addr_i, data_i and write_i stable from request until ack; the block does not latch them at request time.
REQ-021 Deassertion of enable_i during WAIT SHALL NOT abort the transaction; it completes and acks normally.
REQ-022 enable_i held at 1 through ack SHALL start a new transaction: the FSM goes IDLE after the ack edge, then WAIT on the next edge; minimum spacing between acks is MEM_PENDING+1 cycles.
REQ-023 Addresses with bits above 13 set SHALL alias onto line addr_i[13:5], with no error indication.

Reset
REQ-024 While rst_i=1, the block SHALL immediately (asynchronously) force state=IDLE, count=0 and ack_o=0.
REQ-025 Reset SHALL NOT modify memory contents.
REQ-026 Reset asserted mid-transaction SHALL abort the transaction with no write performed and no ack.
REQ-027 After rst_i deasserts, the first rising edge with enable_i=1 SHALL start a fresh transaction.

Verification
REQ-028 Scenario: preload memory[0]=256'h5; read addr 0x0 with enable_i=1, write_i=0 -> ack_o high exactly in cycle 10, data_o=256'h5, memory unchanged.
REQ-029 Scenario: write addr 0x20 with data_i=256'hDEADBEEF -> memory[1]=256'hDEADBEEF only after the ack edge; a subsequent read of 0x20 returns it.
REQ-030 Scenario: write to addr 0x4000_0400 -> memory[32] is updated (high bits ignored).
REQ-031 Scenario: enable_i pulsed for one cycle only -> ack_o still asserts once, 10 cycles later, then stays 0.
REQ-032 Scenario: enable_i held at 1 continuously -> acks at cycles 10, 21, 32, each ack_o exactly one cycle wide.
REQ-033 Scenario: rst_i asserted at cycle 5 of a write -> ack_o stays 0, target line is unchanged, and ack_o=0 immediately upon rst_i assertion.
